// File: rtl/alu_sequencer_if.sv
// Host and ALU-side signal bundle for alu_sequencer.
// The slave modport is the sequencer view; the master modport is the host/ALU view.
interface alu_sequencer_if;
  logic        req;
  logic        ack;
  logic [2:0]  op;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic [4:0]  f;
  logic        csel;
  logic        ucin;
  logic        srcin;
  logic        notALUOE;
  logic        notShiftOE;
  logic [15:0] aluY;
  logic        aluCout;
  logic        aluZout;
  logic        busy;
  logic        done;
  logic [15:0] resLo;
  logic [15:0] resHi;
  logic        flagC;
  logic        flagZ;

  modport slave (
    input  req, op, opA, opB, aluY, aluCout, aluZout,
    output ack, aluA, aluB, f, csel, ucin, srcin, notALUOE, notShiftOE,
    output busy, done, resLo, resHi, flagC, flagZ
  );

  modport master (
    output req, op, opA, opB, aluY, aluCout, aluZout,
    input  ack, aluA, aluB, f, csel, ucin, srcin, notALUOE, notShiftOE,
    input  busy, done, resLo, resHi, flagC, flagZ
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences single-cycle ALU ops and a 16-cycle shift-add multiply through an external ALU.
// Results and flags are held between completions; the ALU bus is released outside EXEC/MUL.
module alu_sequencer (
  input  logic           clk,
  input  logic           notReset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAdc = 3'd2;
  localparam logic [2:0] OpShl = 3'd3;
  localparam logic [2:0] OpShr = 3'd4;
  localparam logic [2:0] OpMul = 3'd5;
  localparam logic [2:0] OpAnd = 3'd6;
  localparam logic [2:0] OpCmp = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] p_q, p_d;
  logic [15:0] m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_lo_q, res_lo_d;
  logic [15:0] res_hi_q, res_hi_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;

  logic        ack;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  f;
  logic        csel, ucin, not_alu_oe, not_shift_oe;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    m_d          = m_q;
    cnt_d        = cnt_q;
    res_lo_d     = res_lo_q;
    res_hi_d     = res_hi_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    ack          = 1'b0;
    alu_a        = 16'h0000;
    alu_b        = 16'h0000;
    f            = 5'b00000;
    csel         = 1'b0;
    ucin         = 1'b0;
    not_alu_oe   = 1'b1;
    not_shift_oe = 1'b1;

    unique case (state_q)
      StIdle: begin
        // Gating with notReset keeps ack low while reset is held.
        if (bus.req && notReset) begin
          ack     = 1'b1;
          op_d    = bus.op;
          a_d     = bus.opA;
          b_d     = bus.opB;
          p_d     = 16'h0000;
          m_d     = bus.opA;
          cnt_d   = 4'd0;
          state_d = (bus.op == OpMul) ? StMul : StExec;
        end
      end

      StExec: begin
        alu_a = a_q;
        alu_b = b_q;
        case (op_q)
          OpSub, OpCmp: begin
            f          = 5'b01100;
            ucin       = 1'b1;
            not_alu_oe = 1'b0;
          end
          OpAdc: begin
            f          = 5'b10010;
            csel       = 1'b1;
            not_alu_oe = 1'b0;
          end
          OpAnd: begin
            f          = 5'b10111;
            not_alu_oe = 1'b0;
          end
          OpShl: begin
            f            = 5'b00101;
            not_shift_oe = 1'b0;
          end
          OpShr: begin
            f            = 5'b00010;
            not_shift_oe = 1'b0;
          end
          default: begin
            f          = 5'b10010;
            not_alu_oe = 1'b0;
          end
        endcase
        if (op_q != OpCmp) begin
          res_lo_d = bus.aluY;
          res_hi_d = 16'h0000;
        end
        flag_c_d = bus.aluCout;
        flag_z_d = bus.aluZout;
        state_d  = StDone;
      end

      StMul: begin
        f          = 5'b10010;
        not_alu_oe = 1'b0;
        alu_a      = p_q;
        alu_b      = m_q[0] ? b_q : 16'h0000;
        {p_d, m_d} = {bus.aluCout, bus.aluY, m_q[15:1]};
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          res_hi_d = p_d;
          res_lo_d = m_d;
          flag_z_d = ({p_d, m_d} == 32'h0000_0000);
          flag_c_d = (p_d != 16'h0000);
          state_d  = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      p_q      <= 16'h0000;
      m_q      <= 16'h0000;
      cnt_q    <= 4'd0;
      res_lo_q <= 16'h0000;
      res_hi_q <= 16'h0000;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign bus.ack        = ack;
  assign bus.aluA       = alu_a;
  assign bus.aluB       = alu_b;
  assign bus.f          = f;
  assign bus.csel       = csel;
  assign bus.ucin       = ucin;
  assign bus.srcin      = flag_c_q;
  assign bus.notALUOE   = not_alu_oe;
  assign bus.notShiftOE = not_shift_oe;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.resLo      = res_lo_q;
  assign bus.resHi      = res_hi_q;
  assign bus.flagC      = flag_c_q;
  assign bus.flagZ      = flag_z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached to its control bus.
// Drivers queue expected results at accept; a negedge monitor checks them on each done pulse.
module tb_alu_sequencer;

  logic clk;
  logic notReset;
  int   tests;
  int   fails;
  int   cyc;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk      (clk),
    .notReset (notReset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: decodes the control word and drives results back to the sequencer.
  logic [16:0] alu_sum;
  logic [15:0] alu_y;
  logic        alu_co;
  logic        alu_cin;
  always_comb begin
    alu_sum = 17'h0;
    alu_y   = 16'h0;
    alu_co  = 1'b0;
    alu_cin = bus.csel ? bus.srcin : bus.ucin;
    if (!bus.notShiftOE) begin
      if (bus.f == 5'b00101) begin
        alu_y  = {bus.aluA[14:0], 1'b0};
        alu_co = bus.aluA[15];
      end else if (bus.f == 5'b00010) begin
        alu_y  = {1'b0, bus.aluA[15:1]};
        alu_co = bus.aluA[0];
      end
    end else if (!bus.notALUOE) begin
      if (bus.f == 5'b10010) begin
        alu_sum = {1'b0, bus.aluA} + {1'b0, bus.aluB} + {16'h0, alu_cin};
        alu_y   = alu_sum[15:0];
        alu_co  = alu_sum[16];
      end else if (bus.f == 5'b01100) begin
        alu_sum = {1'b0, bus.aluA} + {1'b0, ~bus.aluB} + {16'h0, alu_cin};
        alu_y   = alu_sum[15:0];
        alu_co  = alu_sum[16];
      end else if (bus.f == 5'b10111) begin
        alu_y = bus.aluA & bus.aluB;
      end
    end
  end
  assign bus.aluY    = alu_y;
  assign bus.aluCout = alu_co;
  assign bus.aluZout = (alu_y == 16'h0);

  typedef struct {
    string       name;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [15:0] lo, input logic [15:0] hi,
                      input logic c, input logic z, input int lat);
    exp_t e;
    e.name = name;
    e.lo   = lo;
    e.hi   = hi;
    e.c    = c;
    e.z    = z;
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    if (bus.ack && bus.busy) begin
      tests++;
      fails++;
      $display("FAIL ack_while_busy: got ack=1 busy=1, expected ack=0");
    end
    if (bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_resLo"}, {16'h0, bus.resLo}, {16'h0, e.lo});
        chk({e.name, "_resHi"}, {16'h0, bus.resHi}, {16'h0, e.hi});
        chk({e.name, "_flagC"}, {31'h0, bus.flagC}, {31'h0, e.c});
        chk({e.name, "_flagZ"}, {31'h0, bus.flagZ}, {31'h0, e.z});
        chk({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy=1 after 40 cycles, expected idle", name);
    end
    #1;
    chk({name, "_idle_ctrl"},
        {22'h0, bus.f, bus.csel, bus.ucin, bus.notALUOE, bus.notShiftOE},
        {22'h0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1});
    chk({name, "_idle_bus"}, {bus.aluA, bus.aluB}, 32'h0);
  endtask

  // ctrl_e = {f, ucin, csel, notALUOE, notShiftOE, srcin} expected in the first busy cycle.
  task automatic issue(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] lo, input logic [15:0] hi,
                       input logic c, input logic z, input logic [9:0] ctrl_e);
    logic [15:0] ea, eb;
    @(negedge clk);
    bus.req = 1'b1;
    bus.op  = op;
    bus.opA = a;
    bus.opB = b;
    #1;
    chk({name, "_ack"}, {31'h0, bus.ack}, 32'h1);
    push(name, lo, hi, c, z, (op == 3'd5) ? 17 : 2);
    @(negedge clk);
    // Hold req and scramble operands: neither may affect the running op.
    bus.opA = ~a;
    bus.opB = ~b;
    bus.op  = ~op;
    #1;
    chk({name, "_no_ack_busy"}, {30'h0, bus.ack, bus.busy}, 32'h1);
    chk({name, "_ctrl"},
        {22'h0, bus.f, bus.ucin, bus.csel, bus.notALUOE, bus.notShiftOE, bus.srcin},
        {22'h0, ctrl_e});
    ea = (op == 3'd5) ? 16'h0000 : a;
    eb = (op == 3'd5) ? (a[0] ? b : 16'h0000) : b;
    chk({name, "_operands"}, {bus.aluA, bus.aluB}, {ea, eb});
    bus.req = 1'b0;
    wait_idle(name);
  endtask

  localparam logic [4:0] FAdd = 5'b10010;
  localparam logic [4:0] FSub = 5'b01100;
  localparam logic [4:0] FAnd = 5'b10111;
  localparam logic [4:0] FShl = 5'b00101;
  localparam logic [4:0] FShr = 5'b00010;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    notReset = 1'b0;
    bus.req  = 1'b1;
    bus.op   = 3'd0;
    bus.opA  = 16'h1111;
    bus.opB  = 16'h2222;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ack_busy_done", {29'h0, bus.ack, bus.busy, bus.done}, 32'h0);
    chk("reset_results", {bus.resHi, bus.resLo}, 32'h0);
    chk("reset_flags", {30'h0, bus.flagC, bus.flagZ}, 32'h0);
    chk("reset_ctrl", {22'h0, bus.f, bus.csel, bus.ucin, bus.notALUOE, bus.notShiftOE},
        {22'h0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1});
    bus.req = 1'b0;
    @(negedge clk);
    notReset = 1'b1;

    issue("mul_ffff", 3'd5, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0,
          {FAdd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    issue("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1,
          {FAdd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    issue("adc",      3'd2, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 1'b0, 1'b0,
          {FAdd, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    issue("sub",      3'd1, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0,
          {FSub, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    issue("cmp_lt",   3'd7, 16'h0003, 16'h0005, 16'h0002, 16'h0000, 1'b0, 1'b0,
          {FSub, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    issue("and",      3'd6, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 1'b0,
          {FAnd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    issue("shl",      3'd3, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 1'b1, 1'b0,
          {FShl, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    issue("shr",      3'd4, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1,
          {FShr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    issue("mul_3x5",  3'd5, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0,
          {FAdd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    issue("mul_zero", 3'd5, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1,
          {FAdd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    issue("cmp_eq",   3'd7, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b1,
          {FSub, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

    // req held high: accepts land on every third cycle (IDLE, EXEC, DONE).
    @(negedge clk);
    bus.req = 1'b1;
    bus.op  = 3'd0;
    bus.opA = 16'h0001;
    bus.opB = 16'h0002;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("held_req_ack%0d", i), {31'h0, bus.ack}, {31'h0, (i % 3) == 0});
      if ((i % 3) == 0) push($sformatf("held_req%0d", i), 16'h0003, 16'h0000, 1'b0, 1'b0, 2);
      @(negedge clk);
    end
    bus.req = 1'b0;
    wait_idle("held_req");

    issue("mul_shift", 3'd5, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b0,
          {FAdd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    // Reset in the eighth MUL cycle: everything clears at once and no done follows.
    @(negedge clk);
    bus.req = 1'b1;
    bus.op  = 3'd5;
    bus.opA = 16'hFFFF;
    bus.opB = 16'hFFFF;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("mid_mul_busy", {31'h0, bus.busy}, 32'h1);
    #1;
    notReset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_mid_results", {bus.resHi, bus.resLo}, 32'h0);
    chk("rst_mid_flags", {30'h0, bus.flagC, bus.flagZ}, 32'h0);
    chk("rst_mid_oe", {30'h0, bus.notALUOE, bus.notShiftOE}, 32'h3);
    @(negedge clk);
    notReset = 1'b1;
    repeat (25) @(negedge clk);

    issue("add_after_rst", 3'd0, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1'b0,
          {FAdd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
